// File: rtl/mem_fill_ctrl.sv
// Block-fill / write-through initiator: owns the single-cycle memory port, streams an aligned
// block to the cache one word per cycle on a miss, or performs one word write.
module mem_fill_ctrl #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fill_valid,
  output logic [IDX_W-1:0]      fill_word_idx,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [15:0]           fill_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ADDR_WIDTH'((2 * WORDS_PER_BLOCK) - 1);
  localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);

  state_t                state;
  logic [IDX_W-1:0]      k;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // base is block aligned, so base + 2k never carries out of the block.
  assign cur_addr = base + ADDR_WIDTH'({k, 1'b0});
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      base          <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done          <= 1'b0;
      fill_valid    <= 1'b0;
      fill_word_idx <= '0;
      fill_addr     <= '0;
      fill_data     <= '0;
    end else begin
      done       <= 1'b0;
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            state     <= WRITE;
            wr_addr_q <= {wr_addr[ADDR_WIDTH-1:1], 1'b0};
            wr_data_q <= wr_data;
          end else if (miss_req) begin
            state <= FILL;
            base  <= miss_addr & ~BLK_MASK;
            k     <= '0;
          end
        end
        FILL: begin
          fill_data     <= mem_data_out;
          fill_addr     <= cur_addr;
          fill_word_idx <= k;
          fill_valid    <= 1'b1;
          k             <= k + 1'b1;
          if (k == LAST_WORD) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        WRITE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory pins decode only from registered state so requests never reach them combinationally.
  always_comb begin
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    case (state)
      FILL: begin
        mem_addr   = cur_addr;
        mem_enable = 1'b1;
      end
      WRITE: begin
        mem_addr    = wr_addr_q;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_data_in = wr_data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Scoreboard bench for mem_fill_ctrl: directed fills/writes against a behavioural memory.
module tb_mem_fill_ctrl;
  localparam int AW = 16;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req, wr_req;
  logic [AW-1:0] miss_addr, wr_addr;
  logic [15:0]   wr_data;
  logic          busy, done, fill_valid;
  logic [2:0]    fill_word_idx;
  logic [AW-1:0] fill_addr, mem_addr;
  logic [15:0]   fill_data, mem_data_in, mem_data_out;
  logic          mem_enable, mem_wr;

  always #5 clk = ~clk;

  mem_fill_ctrl #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(N)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .fill_valid(fill_valid),
    .fill_word_idx(fill_word_idx), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Background contents; the 0x1230 block holds 0xA000+i.
  function automatic logic [15:0] pattern(input logic [15:0] a);
    if (a[15:4] == 12'h123) return 16'hA000 | {13'h0, a[3:1]};
    return a ^ 16'h5A5A;
  endfunction

  // Memory model: unwritten words read the background pattern.
  logic [15:0] wmem [0:32767];
  bit          wset [0:32767];
  always_comb mem_data_out = wset[mem_addr[15:1]] ? wmem[mem_addr[15:1]] : pattern(mem_addr);
  always @(posedge clk)
    if (mem_enable && mem_wr) begin
      wmem[mem_addr[15:1]] <= mem_data_in;
      wset[mem_addr[15:1]] <= 1'b1;
    end

  logic [15:0] exp_wr [logic [15:0]];
  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (exp_wr.exists(a)) return exp_wr[a];
    return pattern(a);
  endfunction

  typedef struct {
    bit          is_wr;
    logic [2:0]  idx;
    logic [15:0] addr;
    logic [15:0] data;
    bit          last;
  } ev_t;
  ev_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every fill_valid/done cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (fill_valid || done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'h0, fill_valid, done}, 32'h0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_wr) begin
          chk("wr_done_valid", {30'h0, fill_valid, done}, 32'h1);
        end else begin
          chk("fill_flags", {30'h0, fill_valid, done}, {30'h0, 1'b1, e.last});
          chk("fill_idx", fill_word_idx, e.idx);
          chk("fill_addr", fill_addr, e.addr);
          chk("fill_data", fill_data, e.data);
        end
      end
    end
  end

  task automatic push_fill(input logic [15:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      ev_t e;
      e.is_wr = 1'b0;
      e.idx   = 3'(i);
      e.addr  = base + 16'(2 * i);
      e.data  = exp_word(e.addr);
      e.last  = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Request must already be set; acceptance happens at the next edge.
  task automatic fill_track(input logic [15:0] base, input bit hold);
    for (int i = 0; i < N; i++) begin
      logic [15:0] ea;
      ea = base + 16'(2 * i);
      @(posedge clk); #1;
      chk("fill_busy", busy, 1);
      chk("fill_mem_addr", mem_addr, ea);
      chk("fill_mem_en_wr", {mem_enable, mem_wr}, 2'b10);
      if (i == 0) chk("fill_no_valid_at_accept", fill_valid, 0);
    end
    @(posedge clk); #1;
    chk("fill_done", done, 1);
    chk("fill_busy_fall", busy, 0);
    chk("fill_mem_idle", {mem_enable, mem_addr}, 0);
    if (!hold) miss_req = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    e = '{is_wr: 1'b1, idx: 3'h0, addr: 16'h0, data: 16'h0, last: 1'b1};
    exp_q.push_back(e);
    exp_wr[{addr[15:1], 1'b0}] = data;
    wr_req = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    chk("wr_busy", busy, 1);
    chk("wr_mem_en_wr", {mem_enable, mem_wr}, 2'b11);
    chk("wr_mem_addr", mem_addr, {addr[15:1], 1'b0});
    chk("wr_mem_data", mem_data_in, data);
    @(posedge clk); #1;
    chk("wr_done", done, 1);
    chk("wr_busy_fall", busy, 0);
    chk("wr_strobe_off", mem_wr, 0);
    wr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; wr_req = 1'b0;
    miss_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {busy, done, fill_valid}, 0);
    chk("rst_fill_out", {fill_word_idx, fill_addr, fill_data}, 0);
    chk("rst_mem_out", {mem_enable, mem_wr, mem_addr}, 0);
    chk("rst_mem_din", mem_data_in, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fill
    push_fill(16'h1230, N);
    miss_addr = 16'h1235; miss_req = 1'b1;
    fill_track(16'h1230, 1'b0);
    @(posedge clk); #1;

    // Write-through then read it back
    do_write(16'h0041, 16'hBEEF);
    @(posedge clk); #1;
    push_fill(16'h0040, N);
    miss_addr = 16'h0047; miss_req = 1'b1;
    fill_track(16'h0040, 1'b0);
    @(posedge clk); #1;

    // Priority: write first, held miss starts after done
    miss_addr = 16'h2000; miss_req = 1'b1;
    do_write(16'h0101, 16'h1111);
    push_fill(16'h2000, N);
    fill_track(16'h2000, 1'b0);
    @(posedge clk); #1;

    // Reset after the 4th fill_valid
    push_fill(16'h3000, 4);
    miss_addr = 16'h3004; miss_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_valid_idx", {fill_valid, fill_word_idx}, {1'b1, 3'd3});
    rst = 1'b1; miss_req = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_flags", {busy, done, fill_valid}, 0);
    chk("post_rst_fill_out", {fill_word_idx, fill_addr, fill_data}, 0);
    chk("post_rst_mem_out", {mem_enable, mem_wr, mem_addr, mem_data_in}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", {busy, done, fill_valid}, 0);
    push_fill(16'h3000, N);
    miss_addr = 16'h3000; miss_req = 1'b1;
    fill_track(16'h3000, 1'b0);
    @(posedge clk); #1;

    // Top block, no wrap
    push_fill(16'hFFF0, N);
    miss_addr = 16'hFFFF; miss_req = 1'b1;
    fill_track(16'hFFF0, 1'b0);
    @(posedge clk); #1;

    // Back-to-back: request held through done
    push_fill(16'h0500, N);
    miss_addr = 16'h0502; miss_req = 1'b1;
    fill_track(16'h0500, 1'b1);
    miss_addr = 16'h0600;
    push_fill(16'h0600, N);
    fill_track(16'h0600, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
